// File: rtl/alu_issue_muldiv_pkg.sv
// Shared encodings for the ALU-control / multiply-divide issue block.
//   - ALU Sel codes driven to the combinational ALU
//   - R-type funct codes and main-control ALUOp codes
//   - writeback source codes (ALU / HI / LO)
//   - engine state enum and the multiply/divide request struct
package alu_issue_muldiv_pkg;

    // ALU Sel codes
    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;

    // R-type funct codes
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_SLT   = 6'h2A;

    // Main-control ALUOp codes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_OR    = 2'b11;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_HI  = 2'b01;
    localparam logic [1:0] WB_LO  = 2'b10;

    typedef enum logic {ST_IDLE, ST_BUSY} md_state_e;

    typedef struct packed {
        logic is_div;
        logic is_signed;
    } md_req_t;

    // funct 18..1B: bit1 selects divide, bit0 selects unsigned
    function automatic md_req_t funct_to_req(input logic [1:0] f_lo);
        md_req_t r;
        r.is_div    = f_lo[1];
        r.is_signed = ~f_lo[0];
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_muldiv_muldiv_core.sv
// Iterative 32-step multiply / divide engine.
//   clk, rst_n      : clock, async active-low reset (aborts any operation)
//   start           : accept a new operation (only honoured when idle)
//   req             : {is_div, is_signed}
//   op1, op2        : multiplicand/dividend, multiplier/divisor (raw)
//   busy            : engine not idle
//   done            : last iteration happens on the coming edge
//   res_hi, res_lo  : final sign-corrected result, valid while done=1
// Multiply is shift-add on {upper, multiplier}; divide is restoring
// shift-subtract on {remainder, quotient}. Both share one 2*WIDTH register.
module muldiv_core
    import alu_issue_muldiv_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  md_req_t          req,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);
    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e          state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mcand;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   dividend_raw;
    logic               is_div_q;
    logic               neg_q;      // negate product / quotient
    logic               neg_rem_q;  // negate remainder (dividend sign)
    logic               div0_q;

    // operand magnitudes at issue
    logic             sa, sb;
    logic [WIDTH-1:0] mag1, mag2;
    assign sa   = req.is_signed & op1[WIDTH-1];
    assign sb   = req.is_signed & op2[WIDTH-1];
    assign mag1 = sa ? (~op1 + 1'b1) : op1;
    assign mag2 = sb ? (~op2 + 1'b1) : op2;

    // one iteration step
    logic [WIDTH:0]     mul_sum, div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] acc_nxt;
    always_comb begin
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        div_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_ge  = (div_sh >= {1'b0, mcand});
        div_rem = div_ge ? WIDTH'(div_sh - {1'b0, mcand}) : div_sh[WIDTH-1:0];
        if (is_div_q) acc_nxt = {div_rem, acc[WIDTH-2:0], div_ge};
        else          acc_nxt = {mul_sum, acc[WIDTH-1:1]};
    end

    assign busy = (state == ST_BUSY);
    assign done = busy && (cnt == CW'(WIDTH - 1));

    // sign fix on the final iteration's value
    logic [2*WIDTH-1:0] prod_fix;
    always_comb begin
        prod_fix = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
        if (!is_div_q) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else if (div0_q) begin
            res_hi = dividend_raw;
            res_lo = DIV0_LO;
        end else begin
            res_lo = neg_q ? (~acc_nxt[WIDTH-1:0] + 1'b1) : acc_nxt[WIDTH-1:0];
            res_hi = neg_rem_q ? (~acc_nxt[2*WIDTH-1:WIDTH] + 1'b1)
                               : acc_nxt[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            acc          <= '0;
            mcand        <= '0;
            dividend_raw <= '0;
            is_div_q     <= 1'b0;
            neg_q        <= 1'b0;
            neg_rem_q    <= 1'b0;
            div0_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state        <= ST_BUSY;
                        cnt          <= '0;
                        is_div_q     <= req.is_div;
                        neg_q        <= sa ^ sb;
                        neg_rem_q    <= sa;
                        div0_q       <= req.is_div && (op2 == '0);
                        dividend_raw <= op1;
                        // low half holds the operand consumed bit by bit
                        acc          <= {{WIDTH{1'b0}}, (req.is_div ? mag1 : mag2)};
                        mcand        <= req.is_div ? mag2 : mag1;
                    end
                end
                ST_BUSY: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/alu_issue_muldiv.sv
// ALU control decode plus HI/LO ownership and multiply/divide issue.
//   i_clk, i_rst_n      : clock, async active-low reset
//   i_valid             : instruction in EX
//   i_aluop, i_funct    : main-control ALUOp, R-type funct
//   i_op1, i_op2        : rs / rt values
//   o_sel               : ALU Sel
//   o_wb_src            : 00 ALU, 01 HI, 10 LO
//   o_hi, o_lo          : architectural HI/LO
//   o_busy              : multiply/divide engine busy
//   o_stall             : hold EX (muldiv/mfhi/mflo against busy engine)
//   o_illegal           : undecoded R-type funct
module alu_issue_muldiv
    import alu_issue_muldiv_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [1:0]       i_aluop,
    input  logic [5:0]       i_funct,
    input  logic [WIDTH-1:0] i_op1,
    input  logic [WIDTH-1:0] i_op2,
    output logic [3:0]       o_sel,
    output logic [1:0]       o_wb_src,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_illegal
);
    logic             is_md, is_mf;
    logic             md_start, md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    md_req_t          md_req;

    always_comb begin
        o_sel     = SEL_ADD;
        o_wb_src  = WB_ALU;
        o_illegal = 1'b0;
        is_md     = 1'b0;
        is_mf     = 1'b0;
        if (i_valid) begin
            case (i_aluop)
                ALUOP_ADD: o_sel = SEL_ADD;
                ALUOP_SUB: o_sel = SEL_SUB;
                ALUOP_OR:  o_sel = SEL_OR;
                default: begin
                    case (i_funct)
                        F_ADD:  o_sel = SEL_ADD;
                        F_SUB:  o_sel = SEL_SUB;
                        F_AND:  o_sel = SEL_AND;
                        F_OR:   o_sel = SEL_OR;
                        F_SLT:  o_sel = SEL_SLT;
                        F_MFHI: begin o_wb_src = WB_HI; is_mf = 1'b1; end
                        F_MFLO: begin o_wb_src = WB_LO; is_mf = 1'b1; end
                        F_MULT, F_MULTU, F_DIV, F_DIVU: is_md = 1'b1;
                        default: o_illegal = 1'b1;
                    endcase
                end
            endcase
        end
    end

    assign md_req = funct_to_req(i_funct[1:0]);
    // o_busy is still high on the completion edge, so a new op waits one edge
    assign o_stall  = i_valid & o_busy & (is_md | is_mf);
    assign md_start = is_md & ~o_busy;

    muldiv_core #(.WIDTH(WIDTH), .DIV0_LO(DIV0_LO)) u_core (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .start  (md_start),
        .req    (md_req),
        .op1    (i_op1),
        .op2    (i_op2),
        .busy   (o_busy),
        .done   (md_done),
        .res_hi (md_hi),
        .res_lo (md_lo)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_hi <= '0;
            o_lo <= '0;
        end else if (md_done) begin
            o_hi <= md_hi;
            o_lo <= md_lo;
        end
    end

endmodule

// File: tb/tb_alu_issue_muldiv.sv
module tb_alu_issue_muldiv;
    logic        i_clk = 1'b0;
    logic        i_rst_n, i_valid;
    logic [1:0]  i_aluop;
    logic [5:0]  i_funct;
    logic [31:0] i_op1, i_op2;
    logic [3:0]  o_sel;
    logic [1:0]  o_wb_src;
    logic [31:0] o_hi, o_lo;
    logic        o_busy, o_stall, o_illegal;

    int n_chk = 0;
    int n_fail = 0;

    alu_issue_muldiv dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_aluop(i_aluop),
        .i_funct(i_funct), .i_op1(i_op1), .i_op2(i_op2), .o_sel(o_sel),
        .o_wb_src(o_wb_src), .o_hi(o_hi), .o_lo(o_lo), .o_busy(o_busy),
        .o_stall(o_stall), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // reference: {HI, LO} from plain arithmetic
    function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        res = '0;
        case (f)
            6'h18: res = 64'(sa * sb);
            6'h19: res = {32'b0, a} * {32'b0, b};
            6'h1A: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb; r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {a % b, a / b};
            end
        endcase
        return res;
    endfunction

    // issue from idle, count busy cycles, check HI/LO
    task automatic run_md(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] e;
        int cyc;
        e = model(f, a, b);
        i_valid = 1'b1; i_aluop = 2'b10; i_funct = f; i_op1 = a; i_op2 = b;
        #1 chk({tag, "_issue_stall"}, o_stall, 0);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        cyc = 0;
        while (o_busy && cyc < 100) begin
            @(posedge i_clk); #1;
            cyc++;
        end
        chk({tag, "_busy_cycles"}, cyc, 32);
        chk({tag, "_hi"}, o_hi, e[63:32]);
        chk({tag, "_lo"}, o_lo, e[31:0]);
    endtask

    logic [1:0] t_aluop [10] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0] t_funct [10] = '{6'h22, 6'h3F, 6'h00, 6'h00, 6'h00, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12};
    logic [3:0] t_sel   [10] = '{4'h6,  4'h2,  4'h2,  4'h6,  4'h1,  4'h0,  4'h1,  4'h7,  4'h2,  4'h2};
    logic [1:0] t_wb    [10] = '{2'd0,  2'd0,  2'd0,  2'd0,  2'd0,  2'd0,  2'd0,  2'd0,  2'd1,  2'd2};
    logic       t_ill   [10] = '{1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0};

    initial begin
        logic [63:0] e;
        logic [5:0]  f;
        logic [31:0] a, b;
        int cnt;

        // reset state
        i_rst_n = 1'b0; i_valid = 1'b0; i_aluop = 2'b10; i_funct = 6'h18;
        i_op1 = 32'h1; i_op2 = 32'h1;
        #12;
        chk("rst_hi", o_hi, 0);
        chk("rst_lo", o_lo, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_sel", o_sel, 4'b0010);
        chk("rst_wb", o_wb_src, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_illegal", o_illegal, 0);
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // decode table while idle
        for (int i = 0; i < 10; i++) begin
            i_valid = 1'b1; i_aluop = t_aluop[i]; i_funct = t_funct[i];
            #1;
            chk($sformatf("dec%0d_sel", i), o_sel, t_sel[i]);
            chk($sformatf("dec%0d_wb", i), o_wb_src, t_wb[i]);
            chk($sformatf("dec%0d_ill", i), o_illegal, t_ill[i]);
            chk($sformatf("dec%0d_stall", i), o_stall, 0);
        end
        i_valid = 1'b0;
        @(posedge i_clk); #1;

        // directed multiply / divide
        run_md("mult_neg1x7", 6'h18, 32'hFFFF_FFFF, 32'd7);
        chk("mult_neg1x7_hi_const", o_hi, 32'hFFFF_FFFF);
        chk("mult_neg1x7_lo_const", o_lo, 32'hFFFF_FFF9);
        run_md("multu_ffx7", 6'h19, 32'hFFFF_FFFF, 32'd7);
        chk("multu_hi_const", o_hi, 32'd6);
        run_md("div_m7_2", 6'h1A, 32'hFFFF_FFF9, 32'd2);
        chk("div_m7_2_lo_const", o_lo, 32'hFFFF_FFFD);
        chk("div_m7_2_hi_const", o_hi, 32'hFFFF_FFFF);
        run_md("divu_100_7", 6'h1B, 32'd100, 32'd7);
        chk("divu_lo_const", o_lo, 32'd14);
        chk("divu_hi_const", o_hi, 32'd2);
        run_md("divu_5_0", 6'h1B, 32'd5, 32'd0);
        chk("div0_hi_const", o_hi, 32'd5);
        chk("div0_lo_const", o_lo, 32'hFFFF_FFFF);
        run_md("div_ovf", 6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_lo_const", o_lo, 32'h8000_0000);
        chk("ovf_hi_const", o_hi, 32'd0);
        run_md("div_neg_0", 6'h1A, 32'hFFFF_FF00, 32'd0);

        // add during busy, MFLO stalled until the result lands
        e = model(6'h18, 32'h1234, 32'h10);
        i_valid = 1'b1; i_aluop = 2'b10; i_funct = 6'h18; i_op1 = 32'h1234; i_op2 = 32'h10;
        @(posedge i_clk); #1;
        i_funct = 6'h20;
        #1;
        chk("busy_add_stall", o_stall, 0);
        chk("busy_add_sel", o_sel, 4'b0010);
        chk("busy_add_busy", o_busy, 1);
        i_valid = 1'b0;
        repeat (4) @(posedge i_clk);
        #1;
        i_valid = 1'b1; i_funct = 6'h12;
        #1;
        chk("mflo_stall_first", o_stall, 1);
        cnt = 0;
        while (o_stall && cnt < 100) begin
            @(posedge i_clk); #1;
            cnt++;
        end
        chk("mflo_stall_cycles", cnt, 28);
        chk("mflo_wb", o_wb_src, 2'b10);
        chk("mflo_lo", o_lo, e[31:0]);
        i_valid = 1'b0;

        // new op held against a busy engine: stalls through completion edge
        e = model(6'h19, 32'hDEAD_BEEF, 32'h1111);
        i_valid = 1'b1; i_aluop = 2'b10; i_funct = 6'h19; i_op1 = 32'hDEAD_BEEF; i_op2 = 32'h1111;
        @(posedge i_clk); #1;
        i_funct = 6'h1A; i_op1 = 32'hFFFF_FC00; i_op2 = 32'd7;
        #1;
        cnt = 0;
        while (o_stall && cnt < 100) begin
            @(posedge i_clk); #1;
            cnt++;
        end
        chk("held_stall_cycles", cnt, 32);
        chk("held_first_hi", o_hi, e[63:32]);
        chk("held_first_lo", o_lo, e[31:0]);
        e = model(6'h1A, 32'hFFFF_FC00, 32'd7);
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        chk("held_accepted_busy", o_busy, 1);
        cnt = 0;
        while (o_busy && cnt < 100) begin
            @(posedge i_clk); #1;
            cnt++;
        end
        chk("held_second_cycles", cnt, 32);
        chk("held_second_hi", o_hi, e[63:32]);
        chk("held_second_lo", o_lo, e[31:0]);

        // reset mid-operation
        i_valid = 1'b1; i_funct = 6'h18; i_op1 = 32'd1000; i_op2 = 32'd77;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk("midrst_busy", o_busy, 0);
        chk("midrst_hi", o_hi, 0);
        chk("midrst_lo", o_lo, 0);
        @(negedge i_clk) i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        run_md("post_rst_3x4", 6'h18, 32'd3, 32'd4);
        chk("post_rst_lo_const", o_lo, 32'd12);

        // randomized multiply / divide
        for (int k = 0; k < 24; k++) begin
            f = 6'h18 + 6'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_md($sformatf("rand%0d_f%h", k, f), f, a, b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
